// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared cell geometry, attribute layout and built-in glyph table for text_render.
package text_pkg;

   localparam int CELL_W    = 8;
   localparam int CELL_H    = 16;
   localparam int TEXT_COLS = 128;
   localparam int TEXT_ROWS = 128;
   localparam int TB_ADDR_W = 14;
   localparam int TB_DEPTH  = TEXT_COLS * TEXT_ROWS;
   localparam int CODE_W    = 7;
   localparam int GLYPH_W   = CELL_W * CELL_H;

   localparam int ATTR_INV_BIT  = 7;
   localparam int ATTR_CODE_MSB = 6;
   localparam int ATTR_CODE_LSB = 0;

   // Glyph line r occupies byte r; the leftmost pixel of a line is the MSB of its byte.
   localparam logic [GLYPH_W-1:0] GLYPH_A     = 128'h00000000_C6C6C6C6_FEC6C66C_38100000;
   localparam logic [GLYPH_W-1:0] GLYPH_B     = 128'h00000000_FC666666_667C6666_66FC0000;
   localparam logic [GLYPH_W-1:0] GLYPH_C     = 128'h00000000_7CC6C0C0_C0C0C0C0_C67C0000;
   localparam logic [GLYPH_W-1:0] GLYPH_ULINE = 128'h0000FF00_00000000_00000000_00000000;
   localparam logic [GLYPH_W-1:0] GLYPH_BLOCK = {GLYPH_W{1'b1}};

   function automatic logic [GLYPH_W-1:0] font_glyph(input logic [CODE_W-1:0] code);
      logic [GLYPH_W-1:0] g;
      case (code)
         7'h41:   g = GLYPH_A;
         7'h42:   g = GLYPH_B;
         7'h43:   g = GLYPH_C;
         7'h5F:   g = GLYPH_ULINE;
         7'h7F:   g = GLYPH_BLOCK;
         default: g = '0;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/font_rom.sv
// rtl/font_rom.sv - 128x128 glyph ROM with one-cycle registered read.
// Contents are compiled in from text_pkg; INIT_FILE is reserved and must stay empty.
module font_rom
   import text_pkg::*;
#(
   parameter string INIT_FILE = ""
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [CODE_W-1:0]  i_code,
   output logic [GLYPH_W-1:0] o_glyph
);

   logic [GLYPH_W-1:0] glyph_q;
   logic [GLYPH_W-1:0] glyph_d;

   assign glyph_d = font_glyph(i_code);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         glyph_q <= '0;
      end else begin
         glyph_q <= glyph_d;
      end
   end

   assign o_glyph = glyph_q;

   if (INIT_FILE != "") begin : g_init_file
      $error("font_rom: external font images are not supported, the glyph table is built in");
   end

endmodule

// File: rtl/text_render.sv
// rtl/text_render.sv - character-cell pixel source: text buffer + font ROM, 3-stage pipeline.
// Optional blinking cursor enabled by defining TEXT_RENDER_CURSOR_EN.
module text_render
   import text_pkg::*;
#(
   parameter int          H_ACTIVE  = 960,
   parameter int          V_ACTIVE  = 1200,
   parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
   parameter logic [23:0] BG_COLOR  = 24'h000000,
   parameter int          BLINK_BIT = 5
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [11:0]          i_x,
   input  logic [11:0]          i_y,
   input  logic                 i_wr_en,
   input  logic [TB_ADDR_W-1:0] i_wr_addr,
   input  logic [7:0]           i_wr_data,
   input  logic [6:0]           i_cur_row,
   input  logic [6:0]           i_cur_col,
   output logic [23:0]          o_color,
   output logic [23:0]          o_color_even
);

   localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
   localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

   logic [6:0]           col_s0;
   logic [6:0]           row_s0;
   logic [TB_ADDR_W-1:0] rd_addr_s0;
   logic                 in_range_s0;
   logic                 cursor_hit_s0;

   assign col_s0      = i_x[9:3];
   assign row_s0      = i_y[10:4];
   assign rd_addr_s0  = {row_s0, col_s0};
   assign in_range_s0 = (i_x < H_LIM) && (i_y < V_LIM);

`ifdef TEXT_RENDER_CURSOR_EN
   logic [7:0] frame_cnt_q;
   logic [7:0] frame_cnt_d;
   logic       origin_q;
   logic       at_origin;

   assign at_origin = (i_x == 12'd0) && (i_y == 12'd0);

   // Count on entry to (0,0) only, so a counter parked at the origin advances once.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (at_origin && !origin_q) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         frame_cnt_q <= 8'd0;
         origin_q    <= 1'b1;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         origin_q    <= at_origin;
      end
   end

   // The new count is used from pixel (0,0) on, so a whole frame shares one blink phase.
   assign cursor_hit_s0 = (row_s0 == i_cur_row) && (col_s0 == i_cur_col)
                          && frame_cnt_d[BLINK_BIT];
`else
   logic unused_cursor;
   assign unused_cursor = ^{i_cur_row, i_cur_col, 8'(BLINK_BIT)};
   assign cursor_hit_s0 = 1'b0;
`endif

   logic [7:0] text_mem [TB_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en && !i_reset) begin
         text_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // S1: text buffer read (old data on same-address write) with cell position delayed alongside
   logic [7:0] attr_q;
   logic [2:0] c1_q;
   logic [3:0] r1_q;
   logic       vld1_q;
   logic       cur1_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         attr_q <= 8'd0;
         c1_q   <= 3'd0;
         r1_q   <= 4'd0;
         vld1_q <= 1'b0;
         cur1_q <= 1'b0;
      end else begin
         attr_q <= text_mem[rd_addr_s0];
         c1_q   <= i_x[2:0];
         r1_q   <= i_y[3:0];
         vld1_q <= in_range_s0;
         cur1_q <= cursor_hit_s0;
      end
   end

   // S2: glyph fetch
   logic [GLYPH_W-1:0] glyph_q;
   logic [2:0]         c2_q;
   logic [3:0]         r2_q;
   logic               vld2_q;
   logic               inv2_q;
   logic               cur2_q;

   font_rom u_font_rom (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_code  (attr_q[ATTR_CODE_MSB:ATTR_CODE_LSB]),
      .o_glyph (glyph_q)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         c2_q   <= 3'd0;
         r2_q   <= 4'd0;
         vld2_q <= 1'b0;
         inv2_q <= 1'b0;
         cur2_q <= 1'b0;
      end else begin
         c2_q   <= c1_q;
         r2_q   <= r1_q;
         vld2_q <= vld1_q;
         inv2_q <= attr_q[ATTR_INV_BIT];
         cur2_q <= cur1_q;
      end
   end

   // S3: bit r*8 + (7-c) is {r, ~c} for a 3-bit c
   logic        pix_on;
   logic [23:0] color_d;
   logic [23:0] color_q;

   always_comb begin
      pix_on  = glyph_q[{r2_q, ~c2_q}] ^ inv2_q ^ cur2_q;
      color_d = BG_COLOR;
      if (vld2_q && pix_on) begin
         color_d = FG_COLOR;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         color_q <= 24'h000000;
      end else begin
         color_q <= color_d;
      end
   end

   assign o_color      = color_q;
   assign o_color_even = color_q;

endmodule
